stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl -- MM:SS BCD stopwatch with run / pause / adjust control.
// A free-running prescaler generates the 1 Hz tick, the 2 Hz adjust tick and
// the 4 Hz blink strobe. Time is kept as four BCD digits; the hex outputs are
// registered copies of the next time value.
// Optional lap (display freeze) feature: define STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
  parameter int CLK_HZ = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause_pulse,
  input  logic       adj,
  input  logic       sel,
  input  logic       lap_pulse,
  output logic [3:0] hex3,
  output logic [3:0] hex2,
  output logic [3:0] hex1,
  output logic [3:0] hex0,
  output logic       adj_out,
  output logic [3:0] blink_mask,
  output logic       en_blink
);

  // Prescaler width and the decode points within one second.
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] P_HALF = PW'(CLK_HZ / 2 - 1);
  localparam logic [PW-1:0] P_Q1   = PW'(CLK_HZ / 4 - 1);
  localparam logic [PW-1:0] P_Q3   = PW'(3 * (CLK_HZ / 4) - 1);

  // Controller states.
  localparam logic [1:0] ST_PAUSED = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_ADJUST = 2'd2;

  // Blink masks: minutes are digits 3..2, seconds are digits 1..0.
  localparam logic [3:0] MASK_MIN = 4'b1100;
  localparam logic [3:0] MASK_SEC = 4'b0011;

  // Increment a BCD 00..59 field, wrapping 59 -> 00.
  function automatic logic [7:0] bcd60_inc(input logic [3:0] tens, input logic [3:0] ones);
    logic [7:0] r;
    if (ones != 4'd9) begin
      r = {tens, ones + 4'd1};
    end else if (tens != 4'd5) begin
      r = {tens + 4'd1, 4'd0};
    end else begin
      r = 8'h00;
    end
    return r;
  endfunction

  logic [PW-1:0] p_q;
  logic [PW-1:0] p_d;
  logic          tick1;
  logic          tick2;

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic          resume_q;
  logic          resume_d;

  // Digit index: 0 = S-ones, 1 = S-tens, 2 = M-ones, 3 = M-tens.
  logic [3:0]    dig_q [4];
  logic [3:0]    dig_d [4];
  logic [3:0]    hex_q [4];
  logic [3:0]    hex_d [4];

  logic [7:0]    sec_next;
  logic [7:0]    min_next;
  logic          sec_at_59;

  logic          adj_out_q;
  logic          adj_out_d;
  logic [3:0]    blink_mask_q;
  logic [3:0]    blink_mask_d;

  // ---------------------------------------------------------------------------
  // Prescaler and tick decode. The counter never stops, so tick phase is
  // independent of run/pause/adjust activity.
  // ---------------------------------------------------------------------------

  // Next prescaler value: count 0..CLK_HZ-1 and wrap.
  always_comb begin
    p_d = (p_q == P_LAST) ? '0 : p_q + 1'b1;
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign tick1    = (p_q == P_LAST);
  assign tick2    = (p_q == P_HALF) || (p_q == P_LAST);
  // Quarter-second blink strobe; p == 0 never matches, so it is low in reset.
  assign en_blink = (p_q == P_Q1) || (p_q == P_HALF) || (p_q == P_Q3) || (p_q == P_LAST);

  // ---------------------------------------------------------------------------
  // Control FSM. adj is checked before pause_pulse so adjust requests win.
  // ---------------------------------------------------------------------------

  // Next-state and resume-flag decode.
  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    case (state_q)
      ST_PAUSED: begin
        if (adj) begin
          state_d  = ST_ADJUST;
          resume_d = 1'b0;
        end else if (pause_pulse) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (adj) begin
          state_d  = ST_ADJUST;
          resume_d = 1'b1;
        end else if (pause_pulse) begin
          state_d = ST_PAUSED;
        end
      end
      ST_ADJUST: begin
        if (!adj) begin
          state_d = resume_q ? ST_RUN : ST_PAUSED;
        end
      end
      default: begin
        state_d  = ST_PAUSED;
        resume_d = 1'b0;
      end
    endcase
  end

  // FSM state and resume flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_PAUSED;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Time keeping. The update is keyed on the current state, so a tick that
  // coincides with RUN -> ADJUST still counts as a running second.
  // ---------------------------------------------------------------------------

  assign sec_next  = bcd60_inc(dig_q[1], dig_q[0]);
  assign min_next  = bcd60_inc(dig_q[3], dig_q[2]);
  assign sec_at_59 = (dig_q[1] == 4'd5) && (dig_q[0] == 4'd9);

  // Next time value: running count with carry, or single-field adjust.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dig_d[i] = dig_q[i];
    end
    if ((state_q == ST_RUN) && tick1) begin
      dig_d[1] = sec_next[7:4];
      dig_d[0] = sec_next[3:0];
      if (sec_at_59) begin
        dig_d[3] = min_next[7:4];
        dig_d[2] = min_next[3:0];
      end
    end else if ((state_q == ST_ADJUST) && tick2) begin
      if (sel) begin
        dig_d[1] = sec_next[7:4];
        dig_d[0] = sec_next[3:0];
      end else begin
        dig_d[3] = min_next[7:4];
        dig_d[2] = min_next[3:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional display freeze. Lap presses are ignored in ADJUST (including the
  // exit cycle) and entering ADJUST always drops the freeze.
  // ---------------------------------------------------------------------------
`ifdef STOPWATCH_LAP_EN
  logic freeze_q;
  logic freeze_d;

  // Freeze toggle decode.
  always_comb begin
    freeze_d = freeze_q;
    if (state_d == ST_ADJUST) begin
      freeze_d = 1'b0;
    end else if (lap_pulse && (state_q != ST_ADJUST)) begin
      freeze_d = ~freeze_q;
    end
  end

  // Freeze flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freeze_q <= 1'b0;
    end else begin
      freeze_q <= freeze_d;
    end
  end
`else
  // Port kept for pin compatibility; nothing listens to it in this build.
  logic unused_lap;
  assign unused_lap = lap_pulse;
`endif

  // Per-digit display source: the live next time, or the held value while frozen.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
`ifdef STOPWATCH_LAP_EN
      assign hex_d[gi] = freeze_d ? hex_q[gi] : dig_d[gi];
`else
      assign hex_d[gi] = dig_d[gi];
`endif
    end
  endgenerate

  // Time digits and display registers; both load in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        dig_q[i] <= 4'd0;
        hex_q[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        dig_q[i] <= dig_d[i];
        hex_q[i] <= hex_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Adjust indicators, registered from the next state so they line up with
  // the state change and follow sel one cycle later.
  // ---------------------------------------------------------------------------

  // Indicator decode.
  always_comb begin
    adj_out_d    = (state_d == ST_ADJUST);
    blink_mask_d = 4'b0000;
    if (state_d == ST_ADJUST) begin
      blink_mask_d = sel ? MASK_SEC : MASK_MIN;
    end
  end

  // Indicator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adj_out_q    <= 1'b0;
      blink_mask_q <= 4'b0000;
    end else begin
      adj_out_q    <= adj_out_d;
      blink_mask_q <= blink_mask_d;
    end
  end

  assign hex3       = hex_q[3];
  assign hex2       = hex_q[2];
  assign hex1       = hex_q[1];
  assign hex0       = hex_q[0];
  assign adj_out    = adj_out_q;
  assign blink_mask = blink_mask_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl -- directed scenarios with a cycle-stamped scoreboard.
// Stimulus pushes expected outputs for a given cycle; the monitor compares
// on the falling edge of that cycle. Lap expectations follow STOPWATCH_LAP_EN.
module tb_stopwatch_ctrl;

  localparam int CLK_HZ = 8;

`ifdef STOPWATCH_LAP_EN
  localparam logic [15:0] EXP_LAP48 = 16'h0005;
  localparam logic [15:0] EXP_LAP64 = 16'h0005;
`else
  localparam logic [15:0] EXP_LAP48 = 16'h0006;
  localparam logic [15:0] EXP_LAP64 = 16'h0008;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       pause_pulse;
  logic       adj;
  logic       sel;
  logic       lap_pulse;
  logic [3:0] hex3;
  logic [3:0] hex2;
  logic [3:0] hex1;
  logic [3:0] hex0;
  logic       adj_out;
  logic [3:0] blink_mask;
  logic       en_blink;

  int cyc    = 0;
  int base   = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    int         id;
    logic [15:0] hex;
    logic       adj;
    logic [3:0] mask;
    logic       blink;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  stopwatch_ctrl #(.CLK_HZ(CLK_HZ)) dut (
    .clk        (clk),
    .rst        (rst),
    .pause_pulse(pause_pulse),
    .adj        (adj),
    .sel        (sel),
    .lap_pulse  (lap_pulse),
    .hex3       (hex3),
    .hex2       (hex2),
    .hex1       (hex1),
    .hex0       (hex0),
    .adj_out    (adj_out),
    .blink_mask (blink_mask),
    .en_blink   (en_blink)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs at cycle base+r; the blink strobe is high on odd prescaler values.
  task automatic push_rel(input int id, input int r, input logic [15:0] h,
                          input logic a, input logic [3:0] m);
    exp_t e;
    e.cyc   = base + r;
    e.id    = id;
    e.hex   = h;
    e.adj   = a;
    e.mask  = m;
    e.blink = ((r % 2) == 1);
    sb_q.push_back(e);
  endtask

  // Expect all-zero outputs in the current cycle (reset is asserted).
  task automatic push_reset(input int id);
    exp_t e;
    e.cyc   = cyc;
    e.id    = id;
    e.hex   = 16'h0000;
    e.adj   = 1'b0;
    e.mask  = 4'b0000;
    e.blink = 1'b0;
    sb_q.push_back(e);
  endtask

  // Advance to 1 time unit after the posedge that starts cycle base+r.
  task automatic wait_rel(input int r);
    while (cyc < base + r) begin
      @(posedge clk);
      #1;
    end
    if (cyc != base + r) begin
      errors++;
      $display("FAIL sched: at cyc %0d, wanted cyc %0d", cyc, base + r);
    end
  endtask

  // Monitor: compare every expectation due in this cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (mon_e.cyc != cyc) begin
        errors++;
        $display("FAIL vec%0d missed: seen at cyc %0d, due cyc %0d", mon_e.id, cyc, mon_e.cyc);
      end else if ({hex3, hex2, hex1, hex0, adj_out, blink_mask, en_blink} !==
                   {mon_e.hex, mon_e.adj, mon_e.mask, mon_e.blink}) begin
        errors++;
        $display("FAIL vec%0d cyc=%0d got hex=%h adj=%b mask=%b blink=%b, need hex=%h adj=%b mask=%b blink=%b",
                 mon_e.id, cyc, {hex3, hex2, hex1, hex0}, adj_out, blink_mask, en_blink,
                 mon_e.hex, mon_e.adj, mon_e.mask, mon_e.blink);
      end else begin
        $display("vec%0d cyc=%0d hex=%h adj=%b mask=%b blink=%b ok",
                 mon_e.id, cyc, {hex3, hex2, hex1, hex0}, adj_out, blink_mask, en_blink);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pause_pulse = 1'b0; adj = 1'b0; sel = 1'b0; lap_pulse = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push_reset(0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    base = cyc;

    // Start running; seconds count on every 8th cycle.
    wait_rel(2);
    pause_pulse = 1'b1;
    push_rel(1, 3,  16'h0000, 1'b0, 4'b0000);
    push_rel(2, 7,  16'h0000, 1'b0, 4'b0000);
    push_rel(3, 8,  16'h0001, 1'b0, 4'b0000);
    push_rel(4, 16, 16'h0002, 1'b0, 4'b0000);
    push_rel(5, 79, 16'h0009, 1'b0, 4'b0000);
    push_rel(6, 80, 16'h0010, 1'b0, 4'b0000);
    wait_rel(3);
    pause_pulse = 1'b0;

    // Pause: time holds.
    wait_rel(81);
    pause_pulse = 1'b1;
    push_rel(7, 90, 16'h0010, 1'b0, 4'b0000);
    wait_rel(82);
    pause_pulse = 1'b0;

    // Adjust minutes from PAUSED for 16 cycles.
    wait_rel(90);
    adj = 1'b1; sel = 1'b0;
    push_rel(8,  91,  16'h0010, 1'b1, 4'b1100);
    push_rel(9,  92,  16'h0110, 1'b1, 4'b1100);
    push_rel(10, 95,  16'h0110, 1'b1, 4'b1100);
    push_rel(11, 104, 16'h0410, 1'b1, 4'b1100);
    wait_rel(106);
    adj = 1'b0;
    push_rel(12, 107, 16'h0410, 1'b0, 4'b0000);

    // Adjust seconds to 59, then minutes to 59.
    wait_rel(110);
    adj = 1'b1; sel = 1'b1;
    push_rel(13, 111, 16'h0410, 1'b1, 4'b0011);
    push_rel(14, 112, 16'h0411, 1'b1, 4'b0011);
    push_rel(15, 304, 16'h0459, 1'b1, 4'b0011);
    wait_rel(305);
    sel = 1'b0;
    push_rel(16, 306, 16'h0459, 1'b1, 4'b1100);
    push_rel(17, 308, 16'h0559, 1'b1, 4'b1100);
    push_rel(18, 524, 16'h5959, 1'b1, 4'b1100);
    wait_rel(525);
    adj = 1'b0;
    push_rel(19, 526, 16'h5959, 1'b0, 4'b0000);
    wait_rel(527);
    pause_pulse = 1'b1;
    push_rel(20, 535, 16'h5959, 1'b0, 4'b0000);
    push_rel(21, 536, 16'h0000, 1'b0, 4'b0000);
    wait_rel(528);
    pause_pulse = 1'b0;

    // adj and pause_pulse together in RUN: adjust wins, then resumes running.
    wait_rel(540);
    adj = 1'b1; pause_pulse = 1'b1;
    push_rel(22, 541, 16'h0000, 1'b1, 4'b1100);
    push_rel(23, 544, 16'h0100, 1'b1, 4'b1100);
    push_rel(24, 548, 16'h0200, 1'b1, 4'b1100);
    wait_rel(541);
    pause_pulse = 1'b0;
    wait_rel(549);
    adj = 1'b0;
    push_rel(25, 550, 16'h0200, 1'b0, 4'b0000);
    push_rel(26, 552, 16'h0201, 1'b0, 4'b0000);

    // Asynchronous reset while running, then restart.
    wait_rel(553);
    rst = 1'b1;
    push_reset(27);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    base = cyc;

    wait_rel(2);
    pause_pulse = 1'b1;
    push_rel(28, 3,  16'h0000, 1'b0, 4'b0000);
    push_rel(29, 8,  16'h0001, 1'b0, 4'b0000);
    push_rel(30, 40, 16'h0005, 1'b0, 4'b0000);
    wait_rel(3);
    pause_pulse = 1'b0;

    // Lap press at 00:05, release press at 00:08.
    wait_rel(41);
    lap_pulse = 1'b1;
    push_rel(31, 48, EXP_LAP48, 1'b0, 4'b0000);
    push_rel(32, 64, EXP_LAP64, 1'b0, 4'b0000);
    wait_rel(42);
    lap_pulse = 1'b0;
    wait_rel(65);
    lap_pulse = 1'b1;
    push_rel(33, 66, 16'h0008, 1'b0, 4'b0000);
    wait_rel(66);
    lap_pulse = 1'b0;
    push_rel(34, 296, 16'h0037, 1'b0, 4'b0000);

    // Reset at 00:37, between clock edges.
    wait_rel(300);
    rst = 1'b1;
    push_reset(35);
    repeat (2) @(posedge clk);
    #1;

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, need 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
